// File: rtl/shared_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : shared_bus_responder
// Brief    : Far-end responder for the L2 shared bus: snoop reply, then
//            memory-latency line return or writeback completion.
// Revision : 1.0 - initial release
// ============================================================================
module shared_bus_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 512,
    parameter int OP_WIDTH    = 8,
    parameter int MEM_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [OP_WIDTH-1:0]   req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LINE_WIDTH-1:0] req_data,
    output logic                  snoop_valid,
    output logic [1:0]            snoop_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [LINE_WIDTH-1:0] rsp_data,
    output logic                  err,
    output logic [15:0]           write_count
);

    localparam int C_OFFS = $clog2(LINE_WIDTH / 8);
    localparam int C_REPL = LINE_WIDTH / ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] C_ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << C_OFFS) - ADDR_WIDTH'(1));
    localparam logic [7:0] C_WAIT_LOAD = 8'(MEM_LATENCY - 1);

    localparam logic [OP_WIDTH-1:0] C_OP_READ  = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] C_OP_WRITE = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] C_OP_RWIM  = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] C_OP_INV   = OP_WIDTH'(4);

    localparam logic [1:0] C_NOHIT = 2'b00;
    localparam logic [1:0] C_HIT   = 2'b01;
    localparam logic [1:0] C_HITM  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SNOOP    = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_RESPOND  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [OP_WIDTH-1:0]   r_op;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_addr_lo;
    logic [LINE_WIDTH-1:0] r_data;
    logic [7:0]            r_cnt;
    logic                  r_err;
    logic [15:0]           r_write_count;

    logic       w_accept;
    logic       w_op_legal;
    logic       w_is_rd;
    logic [1:0] w_snoop_res;
    logic       w_unused_data;

    assign w_accept   = req_valid & req_ready;
    assign w_op_legal = (req_op >= C_OP_READ) && (req_op <= C_OP_INV);
    assign w_is_rd    = (r_op == C_OP_READ) || (r_op == C_OP_RWIM);

    // Writeback payload is absorbed by the modelled memory and never read back.
    assign w_unused_data = ^r_data;

    always_comb begin
        w_snoop_res = C_NOHIT;
        if (w_is_rd) begin
            case (r_addr_lo)
                2'b00:   w_snoop_res = C_HIT;
                2'b01:   w_snoop_res = C_HITM;
                default: w_snoop_res = C_NOHIT;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_op_legal) w_state_nxt = S_SNOOP;
            end
            S_SNOOP: begin
                if ((r_op == C_OP_INV) || (w_snoop_res == C_HITM)) w_state_nxt = S_IDLE;
                else                                                w_state_nxt = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (r_cnt == 8'd0) w_state_nxt = (r_op == C_OP_WRITE) ? S_IDLE : S_RESPOND;
            end
            S_RESPOND: begin
                if (rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_op          <= '0;
            r_addr        <= '0;
            r_addr_lo     <= 2'b00;
            r_data        <= '0;
            r_cnt         <= 8'd0;
            r_err         <= 1'b0;
            r_write_count <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_accept && !w_op_legal;
            if (w_accept) begin
                r_op      <= req_op;
                r_addr    <= req_addr & C_ALIGN_MASK;
                r_addr_lo <= req_addr[1:0];
                r_data    <= req_data;
            end
            if (r_state == S_SNOOP) begin
                r_cnt <= C_WAIT_LOAD;
            end else if ((r_state == S_MEM_WAIT) && (r_cnt != 8'd0)) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if ((r_state == S_MEM_WAIT) && (r_cnt == 8'd0) && (r_op == C_OP_WRITE)) begin
                r_write_count <= r_write_count + 16'd1;
            end
        end
    end

    // Ready is masked while reset is held so nothing is offered during reset.
    assign req_ready    = (r_state == S_IDLE) && !reset;
    assign snoop_valid  = (r_state == S_SNOOP);
    assign snoop_result = snoop_valid ? w_snoop_res : C_NOHIT;
    assign rsp_valid    = (r_state == S_RESPOND);
    assign rsp_data     = rsp_valid ? {C_REPL{r_addr}} : '0;
    assign err          = r_err;
    assign write_count  = r_write_count;

endmodule
`default_nettype wire

// File: tb/tb_shared_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_shared_bus_responder
// Brief    : Self-checking bench for shared_bus_responder against a
//            transaction-age reference model, plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shared_bus_responder;

    localparam int L = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [7:0]   req_op = 8'd0;
    logic [31:0]  req_addr = 32'd0;
    logic [511:0] req_data = '0;
    logic         snoop_valid;
    logic [1:0]   snoop_result;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [511:0] rsp_data;
    logic         err;
    logic [15:0]  write_count;

    int checks = 0;
    int errors = 0;
    int rsp_mode = 0;

    shared_bus_responder #(
        .ADDR_WIDTH(32), .LINE_WIDTH(512), .OP_WIDTH(8), .MEM_LATENCY(L)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
        .snoop_valid(snoop_valid), .snoop_result(snoop_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .err(err), .write_count(write_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        case (rsp_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [511:0] rep(input logic [31:0] a);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = a;
        return v;
    endfunction

    function automatic logic [1:0] snoop_of(input logic [7:0] op, input logic [31:0] a);
        if (op == 8'd1 || op == 8'd3) begin
            if (a % 4 == 0) return 2'b01;
            if (a % 4 == 1) return 2'b10;
        end
        return 2'b00;
    endfunction

    function automatic bit needs_mem(input logic [7:0] op, input logic [31:0] a);
        if (op == 8'd4) return 1'b0;
        if (snoop_of(op, a) == 2'b10) return 1'b0;
        return 1'b1;
    endfunction

    // Reference model: tracks edges elapsed since the accepted operation.
    int unsigned cyc = 0;
    bit          m_busy = 0;
    bit          m_resp = 0;
    int          m_age = 0;
    logic [7:0]  m_op = 8'd0;
    logic [31:0] m_addr = 32'd0;
    bit          m_err = 0;
    logic [15:0] m_wc = 16'd0;

    always @(posedge clk) begin
        cyc++;
        m_err = 0;
        if (reset) begin
            m_busy = 0;
            m_resp = 0;
            m_wc   = 16'd0;
        end else if (!m_busy) begin
            if (req_valid) begin
                if (req_op >= 8'd1 && req_op <= 8'd4) begin
                    m_busy = 1; m_resp = 0; m_age = 0;
                    m_op = req_op; m_addr = req_addr;
                end else begin
                    m_err = 1;
                end
            end
        end else if (m_resp) begin
            if (rsp_ready) begin m_busy = 0; m_resp = 0; end
        end else begin
            m_age++;
            if (m_age == 1 && !needs_mem(m_op, m_addr)) begin
                m_busy = 0;
            end else if (m_age == L + 1) begin
                if (m_op == 8'd2) begin m_wc = m_wc + 16'd1; m_busy = 0; end
                else m_resp = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            logic sv;
            sv = m_busy && !m_resp && (m_age == 0);
            chk("req_ready",    512'(req_ready),    512'(!m_busy && !reset));
            chk("snoop_valid",  512'(snoop_valid),  512'(sv));
            chk("snoop_result", 512'(snoop_result), 512'(sv ? snoop_of(m_op, m_addr) : 2'b00));
            chk("rsp_valid",    512'(rsp_valid),    512'(m_resp));
            chk("rsp_data",     rsp_data,           m_resp ? rep(m_addr & ~32'h3F) : 512'd0);
            chk("err",          512'(err),          512'(m_err));
            chk("write_count",  512'(write_count),  512'(m_wc));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 300) begin step(); n++; end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL wait_ready: got timeout expected req_ready");
        end
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] addr);
        wait_ready();
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        for (int i = 0; i < 16; i++) req_data[i*32 +: 32] = $urandom;
        step();
        req_valid = 1'b0;
        req_op    = 8'($urandom);
        req_addr  = $urandom;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 300) begin step(); n++; end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL wait_rsp: got timeout expected rsp_valid");
        end
    endtask

    initial begin
        int n;
        bit seen;
        logic [511:0] d0;

        repeat (3) step();
        chk("rst_req_ready", 512'(req_ready), 512'd0);
        chk("rst_rsp_data",  rsp_data,        512'd0);
        reset = 1'b0;
        step();
        chk("ready_after_rst", 512'(req_ready), 512'd1);

        // READ with HIT, line data after MEM_LATENCY
        issue(8'd1, 32'h0000_1044);
        chk("read_snoop_v", 512'(snoop_valid),  512'd1);
        chk("read_snoop_r", 512'(snoop_result), 512'(2'b01));
        n = 0;
        while (!rsp_valid && n < 20) begin step(); n++; end
        chk("read_rsp_lat", 512'(n), 512'd5);
        d0 = rep(32'h0000_1040);
        chk("read_rsp_data", rsp_data, d0);

        // READ with HITM, no response
        issue(8'd1, 32'h0000_2001);
        chk("hitm_snoop_r", 512'(snoop_result), 512'(2'b10));
        step();
        chk("hitm_ready", 512'(req_ready), 512'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin if (rsp_valid) seen = 1; step(); end
        chk("hitm_no_rsp", 512'(seen), 512'd0);

        // WRITE x3
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            issue(8'd2, 32'h1234_5603 + 32'(i * 64));
            chk("write_snoop_r", 512'(snoop_result), 512'(2'b00));
            while (!req_ready) begin if (rsp_valid) seen = 1; step(); end
        end
        chk("write_no_rsp", 512'(seen), 512'd0);
        chk("write_count3", 512'(write_count), 512'd3);

        // RWIM held off by rsp_ready low for 10 cycles
        rsp_mode = 1;
        issue(8'd3, 32'h0000_4002);
        wait_rsp(n);
        d0 = rep(32'h0000_4000);
        for (int i = 0; i < 10; i++) begin
            chk("rwim_hold_v", 512'(rsp_valid), 512'd1);
            chk("rwim_hold_d", rsp_data, d0);
            step();
        end
        rsp_mode = 0;
        step();
        chk("rwim_idle", 512'(req_ready), 512'd1);
        chk("rwim_done", 512'(rsp_valid), 512'd0);

        // Illegal op then INVALIDATE
        issue(8'hFF, 32'h0000_7000);
        chk("ill_err",   512'(err),         512'd1);
        chk("ill_snoop", 512'(snoop_valid), 512'd0);
        chk("ill_ready", 512'(req_ready),   512'd1);
        step();
        chk("ill_err_off", 512'(err), 512'd0);
        issue(8'd4, 32'h0000_6000);
        chk("inv_snoop_v", 512'(snoop_valid),  512'd1);
        chk("inv_snoop_r", 512'(snoop_result), 512'(2'b00));
        step();
        chk("inv_ready", 512'(req_ready), 512'd1);
        chk("inv_no_rsp", 512'(rsp_valid), 512'd0);

        // Reset held 3 cycles while RESPOND is pending
        rsp_mode = 1;
        issue(8'd1, 32'h0000_5000);
        wait_rsp(n);
        reset = 1'b1;
        step();
        chk("mid_rst_rsp_v", 512'(rsp_valid),   512'd0);
        chk("mid_rst_ready", 512'(req_ready),   512'd0);
        chk("mid_rst_wc",    512'(write_count), 512'd0);
        step();
        step();
        reset = 1'b0;
        rsp_mode = 0;
        @(negedge clk);
        #1;
        chk("post_rst_ready", 512'(req_ready), 512'd1);
        step();

        // Randomized traffic
        rsp_mode = 2;
        for (int i = 0; i < 60; i++) begin
            logic [7:0] op;
            repeat ($urandom_range(0, 3)) step();
            op = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0) op = 8'hFF;
            issue(op, $urandom);
        end
        rsp_mode = 0;
        wait_ready();
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
